ruta_ctrl_seg: RTL and testbench

//  Pipelined successor of the ID-stage control decoder for the 5-stage MIPS subset.

---
 rtl/ruta_ctrl_seg.sv | 256 +++++++++++++++++++++++++
 tb/tb_ruta_ctrl_seg.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ruta_ctrl_seg.sv
// Pipelined ID-stage control decoder: decodes opcode/funct and carries EX/MEM/WB control through ID/EX, EX/MEM, MEM/WB.
// Latency: SEL_DIR/resetIF/REG_RD/SEL_IM/pc_en/ifid_en are combinational; ctrl_EXE +1, ctrl_MEM +2, ctrl_WB +3 cycles.
// Backpressure: load-use hazard drops pc_en/ifid_en for one cycle and injects a NOP bubble into EX; j/jr flush IF/ID.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode, funct       instr[31:26] / instr[5:0] held in IF/ID
//   rs, rt, rd          register fields from IF/ID
//   SEL_DIR, resetIF    next-PC select and active-low IF/ID flush (ID, comb.)
//   REG_RD, SEL_IM      active-low regfile read enable, immediate extension select (ID, comb.)
//   pc_en, ifid_en      PC and IF/ID load enables (ID, comb.)
//   ctrl_EXE/dest_EX    EX-stage control {ALU_FUN,SEL_ALU,SEL_REG} and destination
//   ctrl_MEM/dest_MEM   MEM-stage control {MEM_RD_n,MEM_WR_n,w_h} and destination
//   ctrl_WB/dest_WB     WB-stage control {DIR_WB,REG_WR_n} and destination
//   illegal_op          one-cycle pulse when an undecodable instruction enters EX
//   stall_cnt           saturating count of load-use stall cycles since reset
module ruta_ctrl_seg #(
    parameter int         REGW      = 5,
    parameter int         CNT_W     = 16,
    parameter logic [5:0] JR_FUNCT  = 6'h08,
    parameter bit         HAZARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [REGW-1:0]  rs,
    input  logic [REGW-1:0]  rt,
    input  logic [REGW-1:0]  rd,
    output logic [1:0]       SEL_DIR,
    output logic             resetIF,
    output logic             REG_RD,
    output logic             SEL_IM,
    output logic             pc_en,
    output logic             ifid_en,
    output logic [4:0]       ctrl_EXE,
    output logic [REGW-1:0]  dest_EX,
    output logic [2:0]       ctrl_MEM,
    output logic [REGW-1:0]  dest_MEM,
    output logic [1:0]       ctrl_WB,
    output logic [REGW-1:0]  dest_WB,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt
);

    // Internal operation codes. jr shares funct 0x08 with the addi opcode,
    // so it is moved to an otherwise unused code.
    localparam logic [5:0] C_J    = 6'h02;
    localparam logic [5:0] C_ADDI = 6'h08;
    localparam logic [5:0] C_SLTI = 6'h0a;
    localparam logic [5:0] C_ANDI = 6'h0c;
    localparam logic [5:0] C_ORI  = 6'h0d;
    localparam logic [5:0] C_JR   = 6'h18;
    localparam logic [5:0] C_ADD  = 6'h20;
    localparam logic [5:0] C_SUB  = 6'h22;
    localparam logic [5:0] C_AND  = 6'h24;
    localparam logic [5:0] C_OR   = 6'h25;
    localparam logic [5:0] C_NOR  = 6'h27;
    localparam logic [5:0] C_SLT  = 6'h2a;
    localparam logic [5:0] C_LW   = 6'h23;
    localparam logic [5:0] C_SH   = 6'h29;
    localparam logic [5:0] C_SW   = 6'h2b;

    localparam logic [4:0] NOP_EXE = 5'b00000;
    localparam logic [2:0] NOP_MEM = 3'b110;
    localparam logic [1:0] NOP_WB  = 2'b11;

    // ---------------- ID decode ----------------
    logic [5:0]      code;
    logic [2:0]      alu_fun;
    logic            sel_alu, sel_reg;
    logic            mem_rd_n, mem_wr_n, w_h;
    logic            dir_wb, reg_wr_n;
    logic            legal, reads_rs, reads_rt, is_j, is_jr, sign_ext;
    logic [4:0]      dec_exe;
    logic [2:0]      dec_mem;
    logic [1:0]      dec_wb;
    logic [REGW-1:0] dec_dest;

    always_comb begin
        if (opcode != 6'h00)        code = opcode;
        else if (funct == JR_FUNCT) code = C_JR;
        else                        code = funct;

        alu_fun  = 3'b000;
        sel_alu  = 1'b0;
        sel_reg  = 1'b0;
        mem_rd_n = 1'b1;
        mem_wr_n = 1'b1;
        w_h      = 1'b0;
        dir_wb   = 1'b1;
        reg_wr_n = 1'b1;
        legal    = 1'b1;
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        sign_ext = 1'b0;

        case (code)
            C_ADD, C_SUB, C_AND, C_OR, C_NOR, C_SLT: begin
                sel_reg  = 1'b1;
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                reg_wr_n = 1'b0;
                case (code)
                    C_SUB:   alu_fun = 3'b001;
                    C_AND:   alu_fun = 3'b010;
                    C_OR:    alu_fun = 3'b011;
                    C_NOR:   alu_fun = 3'b100;
                    C_SLT:   alu_fun = 3'b101;
                    default: alu_fun = 3'b000;
                endcase
            end
            C_ADDI, C_ANDI, C_ORI, C_SLTI: begin
                sel_alu  = 1'b1;
                reads_rs = 1'b1;
                reg_wr_n = 1'b0;
                case (code)
                    C_ANDI:  alu_fun = 3'b010;
                    C_ORI:   alu_fun = 3'b011;
                    C_SLTI:  alu_fun = 3'b101;
                    default: alu_fun = 3'b000;
                endcase
                sign_ext = (code == C_ADDI) || (code == C_SLTI);
            end
            C_LW: begin
                sel_alu  = 1'b1;
                reads_rs = 1'b1;
                mem_rd_n = 1'b0;
                dir_wb   = 1'b0;
                reg_wr_n = 1'b0;
                sign_ext = 1'b1;
            end
            C_SW, C_SH: begin
                sel_alu  = 1'b1;
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                mem_wr_n = 1'b0;
                w_h      = (code == C_SH);
                sign_ext = 1'b1;
            end
            C_J:     is_j = 1'b1;
            C_JR: begin
                is_jr    = 1'b1;
                reads_rs = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign dec_exe  = {alu_fun, sel_alu, sel_reg};
    assign dec_mem  = {mem_rd_n, mem_wr_n, w_h};
    assign dec_wb   = {dir_wb, reg_wr_n};
    assign dec_dest = sel_reg ? rd : rt;

    // ---------------- pipeline registers ----------------
    // The EX stage keeps the whole bundle because its MEM/WB parts travel on.
    logic [4:0]       ex_exe_q,  ex_exe_d;
    logic [2:0]       ex_mem_q,  ex_mem_d;
    logic [1:0]       ex_wb_q,   ex_wb_d;
    logic [REGW-1:0]  ex_dest_q, ex_dest_d;
    logic [2:0]       mem_mem_q, mem_mem_d;
    logic [1:0]       mem_wb_q,  mem_wb_d;
    logic [REGW-1:0]  mem_dest_q, mem_dest_d;
    logic [1:0]       wb_wb_q,   wb_wb_d;
    logic [REGW-1:0]  wb_dest_q, wb_dest_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // ---------------- load-use hazard ----------------
    // A load in EX whose destination is read by the ID instruction. x0 never hazards.
    logic ld_in_ex, rs_hit, rt_hit, stall;

    assign ld_in_ex = ~ex_mem_q[2] && (ex_dest_q != '0);
    assign rs_hit   = reads_rs && (ex_dest_q == rs);
    assign rt_hit   = reads_rt && (ex_dest_q == rt);
    assign stall    = HAZARD_EN && ld_in_ex && (rs_hit || rt_hit);

    // ---------------- ID-stage combinational outputs ----------------
    // A stalled jr must not redirect yet: its rs value is still in flight.
    always_comb begin
        SEL_DIR = 2'b00;
        if (!stall) begin
            if (is_j)       SEL_DIR = 2'b01;
            else if (is_jr) SEL_DIR = 2'b10;
        end
    end

    assign resetIF = ~((is_j || is_jr) && !stall);
    assign REG_RD  = is_j;
    assign SEL_IM  = ~sign_ext;
    assign pc_en   = ~stall;
    assign ifid_en = ~stall;

    always_comb begin
        if (stall || !legal) begin
            ex_exe_d  = NOP_EXE;
            ex_mem_d  = NOP_MEM;
            ex_wb_d   = NOP_WB;
            ex_dest_d = '0;
        end else begin
            ex_exe_d  = dec_exe;
            ex_mem_d  = dec_mem;
            ex_wb_d   = dec_wb;
            ex_dest_d = dec_dest;
        end
        mem_mem_d  = ex_mem_q;
        mem_wb_d   = ex_wb_q;
        mem_dest_d = ex_dest_q;
        wb_wb_d    = mem_wb_q;
        wb_dest_d  = mem_dest_q;
        illegal_d  = !legal && !stall;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_exe_q    <= NOP_EXE;
            ex_mem_q    <= NOP_MEM;
            ex_wb_q     <= NOP_WB;
            ex_dest_q   <= '0;
            mem_mem_q   <= NOP_MEM;
            mem_wb_q    <= NOP_WB;
            mem_dest_q  <= '0;
            wb_wb_q     <= NOP_WB;
            wb_dest_q   <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_exe_q    <= ex_exe_d;
            ex_mem_q    <= ex_mem_d;
            ex_wb_q     <= ex_wb_d;
            ex_dest_q   <= ex_dest_d;
            mem_mem_q   <= mem_mem_d;
            mem_wb_q    <= mem_wb_d;
            mem_dest_q  <= mem_dest_d;
            wb_wb_q     <= wb_wb_d;
            wb_dest_q   <= wb_dest_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_EXE   = ex_exe_q;
    assign dest_EX    = ex_dest_q;
    assign ctrl_MEM   = mem_mem_q;
    assign dest_MEM   = mem_dest_q;
    assign ctrl_WB    = wb_wb_q;
    assign dest_WB    = wb_dest_q;
    assign illegal_op = illegal_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ruta_ctrl_seg.sv
// Bench for ruta_ctrl_seg: table-driven reference model feeding a scoreboard queue.
// Latency: one expected record per cycle, popped and compared on the falling edge.
// Backpressure: a stalled instruction is re-presented until the model says it issued.
module tb_ruta_ctrl_seg;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;

    logic [1:0] sel_dir_0, sel_dir_1;
    logic       reset_if_0, reset_if_1, reg_rd_0, reg_rd_1, sel_im_0, sel_im_1;
    logic       pc_en_0, pc_en_1, ifid_en_0, ifid_en_1, ill_0, ill_1;
    logic [4:0] exe_0, exe_1, dex_0, dex_1, dmem_0, dmem_1, dwb_0, dwb_1;
    logic [2:0] mem_0, mem_1;
    logic [1:0] wb_0, wb_1;
    logic [3:0] cnt_0;
    logic [15:0] cnt_1;

    always #5 clk = ~clk;

    // Main DUT: small counter so saturation is reached.
    ruta_ctrl_seg #(.REGW(5), .CNT_W(4), .JR_FUNCT(6'h08), .HAZARD_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd),
        .SEL_DIR(sel_dir_0), .resetIF(reset_if_0), .REG_RD(reg_rd_0), .SEL_IM(sel_im_0),
        .pc_en(pc_en_0), .ifid_en(ifid_en_0),
        .ctrl_EXE(exe_0), .dest_EX(dex_0), .ctrl_MEM(mem_0), .dest_MEM(dmem_0),
        .ctrl_WB(wb_0), .dest_WB(dwb_0), .illegal_op(ill_0), .stall_cnt(cnt_0)
    );

    // Hazard detection disabled: must never stall.
    ruta_ctrl_seg #(.REGW(5), .CNT_W(16), .JR_FUNCT(6'h08), .HAZARD_EN(1'b0)) dut_nh (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd),
        .SEL_DIR(sel_dir_1), .resetIF(reset_if_1), .REG_RD(reg_rd_1), .SEL_IM(sel_im_1),
        .pc_en(pc_en_1), .ifid_en(ifid_en_1),
        .ctrl_EXE(exe_1), .dest_EX(dex_1), .ctrl_MEM(mem_1), .dest_MEM(dmem_1),
        .ctrl_WB(wb_1), .dest_WB(dwb_1), .illegal_op(ill_1), .stall_cnt(cnt_1)
    );

    // Instruction table: encoding and the control values the architecture defines for it.
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] exe;
        logic [2:0] mem;
        logic [1:0] wb;
        bit use_rd, rs_read, rt_read, sign_imm, is_j, is_jr, legal;
    } ins_t;

    localparam int N_INS = 17;
    localparam int I_ADD = 0, I_LW = 10, I_SW = 11, I_J = 13, I_JR = 14, I_BADOP = 15, I_BADFN = 16;
    ins_t tbl [N_INS];

    initial begin
        //            op     fn     exe       mem     wb     rd rs rt sx j jr ok
        tbl[0]  = '{6'h00, 6'h20, 5'b00001, 3'b110, 2'b10, 1, 1, 1, 0, 0, 0, 1}; // add
        tbl[1]  = '{6'h00, 6'h22, 5'b00101, 3'b110, 2'b10, 1, 1, 1, 0, 0, 0, 1}; // sub
        tbl[2]  = '{6'h00, 6'h24, 5'b01001, 3'b110, 2'b10, 1, 1, 1, 0, 0, 0, 1}; // and
        tbl[3]  = '{6'h00, 6'h25, 5'b01101, 3'b110, 2'b10, 1, 1, 1, 0, 0, 0, 1}; // or
        tbl[4]  = '{6'h00, 6'h27, 5'b10001, 3'b110, 2'b10, 1, 1, 1, 0, 0, 0, 1}; // nor
        tbl[5]  = '{6'h00, 6'h2a, 5'b10101, 3'b110, 2'b10, 1, 1, 1, 0, 0, 0, 1}; // slt
        tbl[6]  = '{6'h08, 6'h00, 5'b00010, 3'b110, 2'b10, 0, 1, 0, 1, 0, 0, 1}; // addi
        tbl[7]  = '{6'h0c, 6'h00, 5'b01010, 3'b110, 2'b10, 0, 1, 0, 0, 0, 0, 1}; // andi
        tbl[8]  = '{6'h0d, 6'h00, 5'b01110, 3'b110, 2'b10, 0, 1, 0, 0, 0, 0, 1}; // ori
        tbl[9]  = '{6'h0a, 6'h00, 5'b10110, 3'b110, 2'b10, 0, 1, 0, 1, 0, 0, 1}; // slti
        tbl[10] = '{6'h23, 6'h00, 5'b00010, 3'b010, 2'b00, 0, 1, 0, 1, 0, 0, 1}; // lw
        tbl[11] = '{6'h2b, 6'h00, 5'b00010, 3'b100, 2'b11, 0, 1, 1, 1, 0, 0, 1}; // sw
        tbl[12] = '{6'h29, 6'h00, 5'b00010, 3'b101, 2'b11, 0, 1, 1, 1, 0, 0, 1}; // sh
        tbl[13] = '{6'h02, 6'h00, 5'b00000, 3'b110, 2'b11, 0, 0, 0, 0, 1, 0, 1}; // j
        tbl[14] = '{6'h00, 6'h08, 5'b00000, 3'b110, 2'b11, 0, 1, 0, 0, 0, 1, 1}; // jr
        tbl[15] = '{6'h3f, 6'h00, 5'b00000, 3'b110, 2'b11, 0, 0, 0, 0, 0, 0, 0}; // bad opcode
        tbl[16] = '{6'h00, 6'h3f, 5'b00000, 3'b110, 2'b11, 0, 0, 0, 0, 0, 0, 0}; // bad funct
    end

    // Reference pipeline: what each stage register holds.
    typedef struct packed {
        logic [4:0] exe;
        logic [2:0] mem;
        logic [1:0] wb;
        logic [4:0] dest;
    } stage_t;
    localparam stage_t NOP = '{5'b00000, 3'b110, 2'b11, 5'd0};

    stage_t m_ex, m_mem, m_wb;
    bit     m_ill;
    int     m_cnt;
    bit     chk_en;

    typedef struct packed {
        bit         chk;
        logic [1:0] sel_dir;
        logic       reset_if, reg_rd, sel_im, pc_en, ill;
        logic [4:0] exe, dex;
        logic [2:0] mem;
        logic [4:0] dmem;
        logic [1:0] wb;
        logic [4:0] dwb;
        logic [3:0] cnt;
    } exp_t;
    exp_t sb [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive ID inputs, record expected outputs, advance the model.
    task automatic cyc(input int idx, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input bit rst, output bit stalled);
        ins_t   in;
        stage_t dec;
        exp_t   e;
        bit     st;
        in = tbl[idx];
        @(posedge clk);
        #1;
        reset  = rst;
        opcode = in.op;
        funct  = (in.op != 6'h00) ? 6'($urandom_range(0, 63)) : in.fn;
        rs = s; rt = t; rd = d;

        st = (m_ex.mem[2] == 1'b0) && (m_ex.dest != 5'd0) &&
             ((in.rs_read && m_ex.dest == s) || (in.rt_read && m_ex.dest == t));

        e.chk      = chk_en;
        e.sel_dir  = st ? 2'b00 : (in.is_j ? 2'b01 : (in.is_jr ? 2'b10 : 2'b00));
        e.reset_if = !((in.is_j || in.is_jr) && !st);
        e.reg_rd   = in.is_j;
        e.sel_im   = !in.sign_imm;
        e.pc_en    = !st;
        e.ill      = m_ill;
        e.exe = m_ex.exe;   e.dex  = m_ex.dest;
        e.mem = m_mem.mem;  e.dmem = m_mem.dest;
        e.wb  = m_wb.wb;    e.dwb  = m_wb.dest;
        e.cnt = 4'(m_cnt);
        sb.push_back(e);

        dec = '{in.exe, in.mem, in.wb, in.use_rd ? d : t};
        if (rst) begin
            m_ex = NOP; m_mem = NOP; m_wb = NOP; m_ill = 0; m_cnt = 0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (st || !in.legal) ? NOP : dec;
            m_ill = !in.legal;
            if (st && m_cnt < 15) m_cnt++;
        end
        chk_en   = 1'b1;
        stalled  = st;
    endtask

    // Present an instruction until it is accepted (a load-use stall holds it once).
    task automatic issue(input int idx, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        bit st;
        int tries = 0;
        do begin
            cyc(idx, s, t, d, 1'b0, st);
            tries++;
        end while (st && tries < 4);
        if (st) begin
            n_chk++; n_fail++;
            $display("FAIL stall_length: instruction still stalled after %0d cycles", tries);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk) begin
                check("SEL_DIR",    16'(sel_dir_0),  16'(e.sel_dir));
                check("resetIF",    16'(reset_if_0), 16'(e.reset_if));
                check("REG_RD",     16'(reg_rd_0),   16'(e.reg_rd));
                check("SEL_IM",     16'(sel_im_0),   16'(e.sel_im));
                check("pc_en",      16'(pc_en_0),    16'(e.pc_en));
                check("ifid_en",    16'(ifid_en_0),  16'(e.pc_en));
                check("ctrl_EXE",   16'(exe_0),      16'(e.exe));
                check("dest_EX",    16'(dex_0),      16'(e.dex));
                check("ctrl_MEM",   16'(mem_0),      16'(e.mem));
                check("dest_MEM",   16'(dmem_0),     16'(e.dmem));
                check("ctrl_WB",    16'(wb_0),       16'(e.wb));
                check("dest_WB",    16'(dwb_0),      16'(e.dwb));
                check("illegal_op", 16'(ill_0),      16'(e.ill));
                check("stall_cnt",  16'(cnt_0),      16'(e.cnt));
                check("nohaz_pc_en",     16'(pc_en_1),   16'd1);
                check("nohaz_ifid_en",   16'(ifid_en_1), 16'd1);
                check("nohaz_stall_cnt", cnt_1,          16'd0);
            end
        end
    end

    initial begin
        bit st;
        int idx;
        reset = 1'b1; opcode = 6'h0d; funct = 6'h00; rs = '0; rt = '0; rd = '0;
        m_ex = NOP; m_mem = NOP; m_wb = NOP; m_ill = 0; m_cnt = 0;
        chk_en = 1'b0;

        // Reset for two cycles; the first cycle's pipeline contents are unknown.
        cyc(8, 5'd0, 5'd0, 5'd0, 1'b1, st);
        cyc(8, 5'd0, 5'd0, 5'd0, 1'b1, st);

        // add rd=3 followed by fillers so it reaches WB.
        issue(I_ADD, 5'd1, 5'd2, 5'd3);
        repeat (3) issue(8, 5'd0, 5'd9, 5'd0);

        // lw rt=5 then add rs=5: one stall cycle.
        issue(I_LW, 5'd1, 5'd5, 5'd0);
        issue(I_ADD, 5'd5, 5'd2, 5'd6);
        // lw rt=0 then add rs=0: no stall.
        issue(I_LW, 5'd1, 5'd0, 5'd0);
        issue(I_ADD, 5'd0, 5'd0, 5'd7);
        // lw rt=5 then j: j reads nothing, no stall.
        issue(I_LW, 5'd1, 5'd5, 5'd0);
        issue(I_J, 5'd5, 5'd5, 5'd0);
        // lw rt=4 then jr rs=4: stall, then redirect.
        issue(I_LW, 5'd1, 5'd4, 5'd0);
        issue(I_JR, 5'd4, 5'd0, 5'd0);
        // sw reading the loaded register through rt.
        issue(I_LW, 5'd2, 5'd6, 5'd0);
        issue(I_SW, 5'd1, 5'd6, 5'd0);
        // Illegal opcode and illegal funct.
        issue(I_BADOP, 5'd1, 5'd2, 5'd3);
        issue(I_BADFN, 5'd1, 5'd2, 5'd3);
        issue(8, 5'd0, 5'd9, 5'd0);

        // Reset asserted during a stall cycle cancels it.
        issue(I_LW, 5'd1, 5'd7, 5'd0);
        cyc(I_ADD, 5'd7, 5'd1, 5'd2, 1'b1, st);
        issue(I_ADD, 5'd7, 5'd1, 5'd2);

        // Random traffic over few registers and many loads to provoke hazards
        // and drive the small stall counter into saturation.
        for (int i = 0; i < 600; i++) begin
            idx = ($urandom_range(0, 2) == 0) ? I_LW : int'($urandom_range(0, N_INS - 1));
            issue(idx, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
        end

        // Drain the scoreboard, bounded.
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d records left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
